// File: rtl/uart_rx_deframe_if.sv
// Signal bundle between the baud/line side and the UART receive deframer.
// The master side drives tick, line and parity mode; the slave side returns sampled fields.
interface uart_rx_deframe_if;
    logic       baud_tick;
    logic       rx_in;
    logic [1:0] parity_type;
    logic [7:0] raw_data;
    logic       parity_bit;
    logic       start_bit;
    logic       stop_bit;
    logic       recieved_flag;
    logic       active_flag;

    modport master (
        output baud_tick, rx_in, parity_type,
        input  raw_data, parity_bit, start_bit, stop_bit,
        input  recieved_flag, active_flag
    );

    modport slave (
        input  baud_tick, rx_in, parity_type,
        output raw_data, parity_bit, start_bit, stop_bit,
        output recieved_flag, active_flag
    );
endinterface

// File: rtl/uart_rx_deframe.sv
// UART receive deframer: oversampled start/data/parity/stop field capture.
// Optional RX_MAJORITY_VOTE_EN: each bit is the majority of three samples ending at centre.
module uart_rx_deframe #(
    parameter int OVERSAMPLE = 16
) (
    input logic              clock,
    input logic              reset_n,
    uart_rx_deframe_if.slave rx
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CENTRE = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST   = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_en_q, par_en_d;
    logic          start_hold_q, start_hold_d;
    logic          par_hold_q, par_hold_d;
    logic [7:0]    raw_q, raw_d;
    logic          par_out_q, par_out_d;
    logic          start_out_q, start_out_d;
    logic          stop_out_q, stop_out_d;
    logic          flag_q, flag_d;
    logic          active_q, active_d;

    logic          sync1_q, sync2_q;
    logic          rx_s;
    logic          rx_prev_q;
    logic          bit_val;

    assign rx_s = sync2_q;

    // Two-flop synchroniser for the asynchronous serial line
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx.rx_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef RX_MAJORITY_VOTE_EN
    logic rx_prev2_q;

    // Two-tick line history: edge detection and the vote window
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rx_prev_q  <= 1'b1;
            rx_prev2_q <= 1'b1;
        end else if (rx.baud_tick) begin
            rx_prev_q  <= rx_s;
            rx_prev2_q <= rx_prev_q;
        end
    end

    assign bit_val = (rx_prev2_q & rx_prev_q) |
                     (rx_prev2_q & rx_s) |
                     (rx_prev_q & rx_s);
`else
    // Previous-tick line value for falling-edge detection
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rx_prev_q <= 1'b1;
        end else if (rx.baud_tick) begin
            rx_prev_q <= rx_s;
        end
    end

    assign bit_val = rx_s;
`endif

    // Frame FSM and field capture registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_en_q     <= 1'b0;
            start_hold_q <= 1'b0;
            par_hold_q   <= 1'b0;
            raw_q        <= 8'h00;
            par_out_q    <= 1'b0;
            start_out_q  <= 1'b0;
            stop_out_q   <= 1'b1;
            flag_q       <= 1'b0;
            active_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_en_q     <= par_en_d;
            start_hold_q <= start_hold_d;
            par_hold_q   <= par_hold_d;
            raw_q        <= raw_d;
            par_out_q    <= par_out_d;
            start_out_q  <= start_out_d;
            stop_out_q   <= stop_out_d;
            flag_q       <= flag_d;
            active_q     <= active_d;
        end
    end

    // Next-state: advance only on baud ticks, sample at bit centres
    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_en_d     = par_en_q;
        start_hold_d = start_hold_q;
        par_hold_d   = par_hold_q;
        raw_d        = raw_q;
        par_out_d    = par_out_q;
        start_out_d  = start_out_q;
        stop_out_d   = stop_out_q;
        flag_d       = 1'b0;
        active_d     = active_q;

        if (rx.baud_tick) begin
            unique case (state_q)
                S_IDLE: begin
                    if (rx_prev_q && !rx_s) begin
                        state_d    = S_START;
                        tick_cnt_d = '0;
                        par_en_d   = ^rx.parity_type;
                        active_d   = 1'b1;
                    end
                end
                S_START: begin
                    if (tick_cnt_q == CENTRE) begin
                        start_hold_d = bit_val;
                        tick_cnt_d   = '0;
                        bit_cnt_d    = '0;
                        state_d      = S_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + CW'(1);
                    end
                end
                S_DATA: begin
                    if (tick_cnt_q == LAST) begin
                        shift_d    = {bit_val, shift_q[7:1]};
                        tick_cnt_d = '0;
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = par_en_q ? S_PARITY : S_STOP;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + CW'(1);
                    end
                end
                S_PARITY: begin
                    if (tick_cnt_q == LAST) begin
                        par_hold_d = bit_val;
                        tick_cnt_d = '0;
                        state_d    = S_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + CW'(1);
                    end
                end
                S_STOP: begin
                    if (tick_cnt_q == LAST) begin
                        raw_d       = shift_q;
                        start_out_d = start_hold_q;
                        par_out_d   = par_en_q ? par_hold_q : 1'b0;
                        stop_out_d  = bit_val;
                        flag_d      = 1'b1;
                        active_d    = 1'b0;
                        tick_cnt_d  = '0;
                        state_d     = S_IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign rx.raw_data      = raw_q;
    assign rx.parity_bit    = par_out_q;
    assign rx.start_bit     = start_out_q;
    assign rx.stop_bit      = stop_out_q;
    assign rx.recieved_flag = flag_q;
    assign rx.active_flag   = active_q;

endmodule
